// File: rtl/spike_collector.sv
// spike_collector: sequences per-neuron updates for one sample window,
// accumulates spike counts, drives lateral inhibition from the previous
// timestep's fire vector, and resolves the most active neuron at the end.
//
// Handshake with the neuron update stage: o_run is a one-cycle request for
// neuron nidx. The collector then sits in WAIT until i_valid pulses, which
// marks that neuron as finished and qualifies i_spike and i_neuron_idx.
// i_valid is only consumed in WAIT and is dropped in every other state.
module spike_collector #(
  parameter int          N_NEURON = 18,
  parameter int          CNT_W    = 8,
  parameter int          STEP_W   = 9,
  parameter logic [24:0] INH_W    = 25'd1114112
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [STEP_W-1:0] i_n_steps,
  input  logic              i_valid,
  input  logic              i_spike,
  input  logic [4:0]        i_neuron_idx,
  output logic              o_run,
  output logic [24:0]       o_inh_current,
  output logic              o_busy,
  output logic              o_step_done,
  output logic              o_done,
  output logic [4:0]        o_winner,
  output logic [CNT_W-1:0]  o_winner_cnt,
  output logic              o_err,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT     = 3'd2,
    S_STEP_END = 3'd3,
    S_RESOLVE  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [4:0]       LAST_IDX = 5'(N_NEURON - 1);
  localparam logic [4:0]       NO_WIN   = 5'd31;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [30:0]      INH_SAT  = 31'h0FFFFFF;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   n_steps_q;
  logic [STEP_W-1:0]   step_q;
  logic [4:0]          nidx_q;
  logic [N_NEURON-1:0] cur_fired_q;
  logic [N_NEURON-1:0] prev_fired_q;
  logic [CNT_W-1:0]    cnt_q [N_NEURON];
  logic                err_q;
  logic [4:0]          best_idx_q;
  logic [CNT_W-1:0]    best_cnt_q;
  logic [4:0]          winner_q;
  logic [CNT_W-1:0]    winner_cnt_q;

  logic                start_acc;
  logic                last_step;
  logic [5:0]          pop;
  logic [5:0]          inh_cnt;
  logic [30:0]         inh_prod;
  logic [24:0]         inh_sat;
  logic [4:0]          scan_idx;
  logic [CNT_W-1:0]    scan_cnt;

  assign start_acc = (state_q == S_IDLE) && i_start && (i_n_steps != '0);
  assign last_step = (step_q == n_steps_q - STEP_W'(1));

  // Inhibition: every other neuron that fired last timestep contributes one weight.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N_NEURON; i++) begin
      pop = pop + 6'(prev_fired_q[i]);
    end
    inh_cnt  = pop - 6'(prev_fired_q[nidx_q]);
    inh_prod = 31'(INH_W) * 31'(inh_cnt);
    inh_sat  = (inh_prod > INH_SAT) ? INH_SAT[24:0] : inh_prod[24:0];
  end

  // Winner scan step: strict greater-than keeps the lowest index on ties.
  always_comb begin
    scan_idx = best_idx_q;
    scan_cnt = best_cnt_q;
    if (cnt_q[nidx_q] > best_cnt_q) begin
      scan_idx = nidx_q;
      scan_cnt = cnt_q[nidx_q];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start_acc) state_d = S_ISSUE;
      S_ISSUE:    state_d = S_WAIT;
      S_WAIT:     if (i_valid) state_d = (nidx_q == LAST_IDX) ? S_STEP_END : S_ISSUE;
      S_STEP_END: state_d = last_step ? S_RESOLVE : S_ISSUE;
      S_RESOLVE:  if (nidx_q == LAST_IDX) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Datapath: counters, fire vectors, error flag and winner registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_steps_q    <= '0;
      step_q       <= '0;
      nidx_q       <= '0;
      cur_fired_q  <= '0;
      prev_fired_q <= '0;
      err_q        <= 1'b0;
      best_idx_q   <= NO_WIN;
      best_cnt_q   <= '0;
      winner_q     <= NO_WIN;
      winner_cnt_q <= '0;
      for (int i = 0; i < N_NEURON; i++) cnt_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_acc) begin
            n_steps_q    <= i_n_steps;
            step_q       <= '0;
            nidx_q       <= '0;
            cur_fired_q  <= '0;
            prev_fired_q <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < N_NEURON; i++) cnt_q[i] <= '0;
          end
        end
        S_WAIT: begin
          if (i_valid) begin
            // A mismatched index is flagged but the update still lands on nidx.
            if (i_neuron_idx != nidx_q) err_q <= 1'b1;
            if (i_spike) begin
              cur_fired_q[nidx_q] <= 1'b1;
              if (cnt_q[nidx_q] != CNT_MAX) cnt_q[nidx_q] <= cnt_q[nidx_q] + CNT_W'(1);
            end
            nidx_q <= (nidx_q == LAST_IDX) ? 5'd0 : nidx_q + 5'd1;
          end
        end
        S_STEP_END: begin
          prev_fired_q <= cur_fired_q;
          cur_fired_q  <= '0;
          step_q       <= step_q + STEP_W'(1);
          best_idx_q   <= NO_WIN;
          best_cnt_q   <= '0;
        end
        S_RESOLVE: begin
          best_idx_q <= scan_idx;
          best_cnt_q <= scan_cnt;
          if (nidx_q == LAST_IDX) begin
            // Result is loaded on entry to DONE so it is visible with o_done.
            winner_q     <= scan_idx;
            winner_cnt_q <= scan_cnt;
            nidx_q       <= '0;
          end else begin
            nidx_q <= nidx_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_run         = (state_q == S_ISSUE);
  assign o_inh_current = (state_q == S_ISSUE) ? inh_sat : 25'd0;
  assign o_busy        = (state_q != S_IDLE);
  assign o_step_done   = (state_q == S_STEP_END);
  assign o_done        = (state_q == S_DONE);
  assign o_winner      = winner_q;
  assign o_winner_cnt  = winner_cnt_q;
  assign o_err         = err_q;
  assign o_state       = state_q;

endmodule
